// File: rtl/store_serializer.sv
// store_serializer
// Breaks a byte/half/word store into single-byte writes to a byte-wide memory,
// little-endian, one byte per mem_we && mem_ready handshake.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready   request handshake; ready only in IDLE
//   req_addr/data/size    store address, register value, size (00 B, 01 H, 10 W, 11 illegal)
//   mem_we/addr/wdata     byte write to memory, qualified by mem_ready
//   mem_ready             memory accepts the current byte
//   done / err            one-cycle completion / rejection pulses
//   busy                  high whenever not IDLE
module store_serializer #(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_data,
   input  logic [1:0]        req_size,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   input  logic              mem_ready,
   output logic              done,
   output logic              err,
   output logic              busy
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WRITE = 2'd1,
      S_DONE  = 2'd2,
      S_ERR   = 2'd3
   } state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       data_q, data_d;
   logic [1:0]        idx_q, idx_d;
   logic [2:0]        n_q, n_d;
   // Keeps req_ready low while in reset and until the first edge after release.
   logic              live_q;

   logic              legal;
   logic [2:0]        n_req;
   logic              last_byte;

   // Size decode and alignment check of the incoming request.
   always_comb begin
      legal = 1'b0;
      n_req = 3'd0;
      case (req_size)
         2'b00: begin legal = 1'b1;                n_req = 3'd1; end
         2'b01: begin legal = ~req_addr[0];        n_req = 3'd2; end
         2'b10: begin legal = (req_addr[1:0] == 2'b00); n_req = 3'd4; end
         default: begin legal = 1'b0;              n_req = 3'd0; end
      endcase
   end

   assign last_byte = ({1'b0, idx_q} == (n_q - 3'd1));

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      data_d  = data_q;
      idx_d   = idx_q;
      n_d     = n_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid && req_ready) begin
               addr_d  = req_addr;
               data_d  = req_data;
               n_d     = n_req;
               idx_d   = 2'd0;
               state_d = legal ? S_WRITE : S_ERR;
            end
         end
         S_WRITE: begin
            if (mem_ready) begin
               idx_d = idx_q + 2'd1;
               if (last_byte) state_d = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         S_ERR:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         data_q  <= '0;
         idx_q   <= '0;
         n_q     <= '0;
         live_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         idx_q   <= idx_d;
         n_q     <= n_d;
         live_q  <= 1'b1;
      end
   end

   // Outputs are pure decodes of registered state, so the address and byte
   // stay put for as long as the memory stalls.
   always_comb begin
      req_ready = live_q && (state_q == S_IDLE);
      busy      = (state_q != S_IDLE);
      done      = (state_q == S_DONE);
      err       = (state_q == S_ERR);
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = 8'h00;
      if (state_q == S_WRITE) begin
         mem_we   = 1'b1;
         mem_addr = addr_q + ADDR_W'(idx_q);
         case (idx_q)
            2'd0:    mem_wdata = data_q[7:0];
            2'd1:    mem_wdata = data_q[15:8];
            2'd2:    mem_wdata = data_q[23:16];
            default: mem_wdata = data_q[31:24];
         endcase
      end
   end

endmodule

// File: tb/tb_store_serializer.sv
// Bench for store_serializer: a transaction-level model (queue of expected byte
// writes, pending done/err pulse) checked against the DUT every cycle, plus
// directed scenarios with literal expected addresses, bytes and cycle numbers.
module tb_store_serializer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic [31:0] req_data;
   logic [1:0]  req_size;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic        mem_ready;
   logic        done;
   logic        err;
   logic        busy;

   store_serializer #(.ADDR_W(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_addr(req_addr), .req_data(req_data), .req_size(req_size),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ready(mem_ready),
      .done(done), .err(err), .busy(busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input bit ok, input string nm, input longint act, input longint exp);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- model ----------------
   typedef struct {
      logic [31:0] a;
      logic [7:0]  d;
   } wr_t;

   wr_t         exp_q[$];
   bit          exp_done = 0, exp_err = 0;
   bit          armed_m;
   int          cyc = 0;
   int          acc_cyc = -1, done_cyc = -1, err_cyc = -1, rdy_cyc = -1;
   bit          waiting_rdy = 0;
   int          we_cnt = 0, hs_cnt = 0, done_cnt = 0, err_cnt = 0;
   logic [31:0] log_a[$];
   logic [7:0]  log_d[$];
   int          log_c[$];

   // Requests may only be taken once a clock edge has passed out of reset.
   always @(posedge clk or negedge rst_n)
      if (!rst_n) armed_m <= 1'b0;
      else        armed_m <= 1'b1;

   always @(negedge clk) begin
      bit busy_m, ready_m, nd, ne;
      int n;
      cyc++;
      if (mem_we) we_cnt++;
      if (done) done_cnt++;
      if (err) err_cnt++;
      if (!rst_n) begin
         check({req_ready, busy, mem_we, done, err} == 5'b0, "reset_ctl", {req_ready, busy, mem_we, done, err}, 0);
         check(mem_addr == 0 && mem_wdata == 0, "reset_mem", {mem_addr, mem_wdata}, 0);
         exp_q.delete();
         exp_done = 0;
         exp_err = 0;
         waiting_rdy = 0;
      end else begin
         busy_m  = (exp_q.size() > 0) || exp_done || exp_err;
         ready_m = armed_m && !busy_m;
         check(req_ready == ready_m, "req_ready", req_ready, ready_m);
         check(busy == busy_m, "busy", busy, busy_m);
         check(done == exp_done, "done", done, exp_done);
         check(err == exp_err, "err", err, exp_err);
         check(mem_we == (exp_q.size() > 0), "mem_we", mem_we, exp_q.size() > 0);
         if (exp_q.size() > 0) begin
            check(mem_addr == exp_q[0].a, "mem_addr", mem_addr, exp_q[0].a);
            check(mem_wdata == exp_q[0].d, "mem_wdata", mem_wdata, exp_q[0].d);
         end else begin
            check(mem_addr == 0 && mem_wdata == 0, "mem_idle_zero", {mem_addr, mem_wdata}, 0);
         end
         if (exp_done) done_cyc = cyc;
         if (exp_err) err_cyc = cyc;
         if (ready_m && waiting_rdy) begin
            rdy_cyc = cyc;
            waiting_rdy = 0;
         end
         nd = 0;
         ne = 0;
         if (exp_q.size() > 0 && mem_ready) begin
            hs_cnt++;
            log_a.push_back(exp_q[0].a);
            log_d.push_back(exp_q[0].d);
            log_c.push_back(cyc);
            void'(exp_q.pop_front());
            if (exp_q.size() == 0) nd = 1;
         end
         if (ready_m && req_valid) begin
            acc_cyc = cyc;
            waiting_rdy = 1;
            n = (req_size == 2'b00) ? 1 : (req_size == 2'b01) ? 2 : 4;
            if (req_size != 2'b11 && (req_addr % n) == 0) begin
               for (int i = 0; i < n; i++)
                  exp_q.push_back('{a: req_addr + 32'(i), d: 8'((req_data >> (8 * i)) & 32'hFF)});
            end else begin
               ne = 1;
            end
         end
         exp_done = nd;
         exp_err = ne;
      end
   end

   // ---------------- stimulus ----------------
   // Issue one store; mem_ready is low on cycles acc+stall_at+1 .. acc+stall_at+stall_len.
   task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                           input int stall_at, input int stall_len);
      int t, k;
      @(posedge clk); #1;
      req_valid = 1; req_addr = a; req_data = d; req_size = sz;
      t = 0;
      while (!req_ready && t < 50) begin @(posedge clk); #1; t++; end
      check(t < 50, "accept_timeout", t, 0);
      @(posedge clk); #1;
      // Held valid with garbage while busy: must be ignored.
      req_addr = 32'hDEAD_BEEF; req_data = ~d; req_size = 2'b10;
      k = 1;
      mem_ready = !(k > stall_at && k <= stall_at + stall_len);
      while (busy && k < 40) begin
         @(posedge clk); #1;
         req_valid = 0;
         k++;
         mem_ready = !(k > stall_at && k <= stall_at + stall_len);
      end
      check(k < 40, "complete_timeout", k, 0);
      mem_ready = 1;
      @(negedge clk); #1;
   endtask

   task automatic exp_wr(input int i, input logic [31:0] a, input logic [7:0] d, input int c);
      if (i >= log_a.size()) begin
         check(0, "write_missing", i, log_a.size());
      end else begin
         check(log_a[i] == a, "lit_addr", log_a[i], a);
         check(log_d[i] == d, "lit_data", log_d[i], d);
         check(log_c[i] == c, "lit_cycle", log_c[i], c);
      end
   endtask

   initial begin
      int i0, w0, h0, d0, e0;
      logic [31:0] bad_a[3];
      logic [1:0]  bad_s[3];
      rst_n = 0; req_valid = 0; req_addr = 0; req_data = 0; req_size = 0; mem_ready = 1;
      repeat (2) @(posedge clk);
      #1 rst_n = 1;
      check(req_ready == 0, "ready_before_edge", req_ready, 0);
      @(posedge clk); #1;
      check(req_ready == 1, "ready_after_edge", req_ready, 1);

      // SW 0x100
      i0 = log_a.size(); d0 = done_cnt;
      do_store(32'h100, 32'hA1B2C3D4, 2'b10, 0, 0);
      exp_wr(i0 + 0, 32'h100, 8'hD4, acc_cyc + 1);
      exp_wr(i0 + 1, 32'h101, 8'hC3, acc_cyc + 2);
      exp_wr(i0 + 2, 32'h102, 8'hB2, acc_cyc + 3);
      exp_wr(i0 + 3, 32'h103, 8'hA1, acc_cyc + 4);
      check(done_cyc == acc_cyc + 5, "sw_done_cyc", done_cyc - acc_cyc, 5);
      check(rdy_cyc == acc_cyc + 6, "sw_ready_cyc", rdy_cyc - acc_cyc, 6);
      check(done_cnt - d0 == 1, "sw_done_cnt", done_cnt - d0, 1);

      // SH 0x202
      i0 = log_a.size(); w0 = we_cnt;
      do_store(32'h202, 32'hFFFF8765, 2'b01, 0, 0);
      exp_wr(i0 + 0, 32'h202, 8'h65, acc_cyc + 1);
      exp_wr(i0 + 1, 32'h203, 8'h87, acc_cyc + 2);
      check(log_a.size() - i0 == 2, "sh_nwrites", log_a.size() - i0, 2);
      check(we_cnt - w0 == 2, "sh_we_cycles", we_cnt - w0, 2);
      check(done_cyc == acc_cyc + 3, "sh_done_cyc", done_cyc - acc_cyc, 3);

      // SB 0x7
      i0 = log_a.size();
      do_store(32'h7, 32'h123456F0, 2'b00, 0, 0);
      exp_wr(i0, 32'h7, 8'hF0, acc_cyc + 1);
      check(log_a.size() - i0 == 1, "sb_nwrites", log_a.size() - i0, 1);
      check(done_cyc == acc_cyc + 2, "sb_done_cyc", done_cyc - acc_cyc, 2);

      // Rejections
      bad_a = '{32'h3, 32'h2, 32'h40};
      bad_s = '{2'b01, 2'b10, 2'b11};
      for (int j = 0; j < 3; j++) begin
         w0 = we_cnt; e0 = err_cnt; d0 = done_cnt;
         do_store(bad_a[j], 32'h5555AAAA, bad_s[j], 0, 0);
         check(we_cnt == w0, "rej_no_we", we_cnt - w0, 0);
         check(err_cnt - e0 == 1, "rej_err_cnt", err_cnt - e0, 1);
         check(done_cnt == d0, "rej_no_done", done_cnt - d0, 0);
         check(err_cyc == acc_cyc + 1, "rej_err_cyc", err_cyc - acc_cyc, 1);
         check(rdy_cyc == acc_cyc + 2, "rej_ready_cyc", rdy_cyc - acc_cyc, 2);
      end

      // SW with 3 stall cycles on byte 1
      i0 = log_a.size(); w0 = we_cnt; h0 = hs_cnt;
      do_store(32'h300, 32'h11223344, 2'b10, 1, 3);
      exp_wr(i0 + 0, 32'h300, 8'h44, acc_cyc + 1);
      exp_wr(i0 + 1, 32'h301, 8'h33, acc_cyc + 5);
      exp_wr(i0 + 2, 32'h302, 8'h22, acc_cyc + 6);
      exp_wr(i0 + 3, 32'h303, 8'h11, acc_cyc + 7);
      check(hs_cnt - h0 == 4, "stall_handshakes", hs_cnt - h0, 4);
      check(we_cnt - w0 == 7, "stall_we_cycles", we_cnt - w0, 7);
      check(done_cyc == acc_cyc + 8, "stall_done_cyc", done_cyc - acc_cyc, 8);

      // Reset after the 2nd byte of a SW
      h0 = hs_cnt; d0 = done_cnt;
      @(posedge clk); #1;
      req_valid = 1; req_addr = 32'h400; req_data = 32'hCAFEF00D; req_size = 2'b10;
      @(posedge clk); #1;         // accepted (ready was high in IDLE)
      req_valid = 0;
      @(posedge clk); #1;         // byte 0 written
      @(posedge clk); #1;         // byte 1 written, byte 2 presented
      check(mem_we == 1 && mem_addr == 32'h402, "pre_reset_we", {mem_we, mem_addr}, {1'b1, 32'h402});
      rst_n = 0;
      #1;
      check(mem_we == 0 && mem_addr == 0 && mem_wdata == 0, "reset_drop_we", {mem_we, mem_addr, mem_wdata}, 0);
      check(busy == 0, "reset_busy", busy, 0);
      @(posedge clk); #1;
      rst_n = 1;
      check(req_ready == 0, "rel_ready_before_edge", req_ready, 0);
      @(posedge clk); #1;
      check(req_ready == 1, "rel_ready_after_edge", req_ready, 1);
      repeat (3) @(posedge clk);
      #1;
      check(hs_cnt - h0 == 2, "reset_handshakes", hs_cnt - h0, 2);
      check(done_cnt == d0, "reset_no_done", done_cnt - d0, 0);

      // Store after the abort still works
      i0 = log_a.size();
      do_store(32'h500, 32'h0000BEEF, 2'b01, 0, 0);
      exp_wr(i0 + 0, 32'h500, 8'hEF, acc_cyc + 1);
      exp_wr(i0 + 1, 32'h501, 8'hBE, acc_cyc + 2);

      repeat (2) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/store_serializer.md
STORE_SERIALIZER -- requirements
Module: store_serializer

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width of request and memory port.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req_valid  input  1  store request present.
REQ-005 SHALL have port req_ready  output  1  block can accept a request.
REQ-006 SHALL have port req_addr  input  ADDR_W  byte address of store.
REQ-007 SHALL have port req_data  input  32  register value to store.
REQ-008 SHALL have port req_size  input  2  00 byte (SB), 01 half (SH), 10 word (SW), 11 illegal.
REQ-009 SHALL have port mem_we  output  1  byte write strobe to byte-wide memory.
REQ-010 SHALL have port mem_addr  output  ADDR_W  byte address of current write.
REQ-011 SHALL have port mem_wdata  output  8  byte being written.
REQ-012 SHALL have port mem_ready  input  1  memory accepts write when mem_we && mem_ready.
REQ-013 SHALL have port done  output  1  one-cycle pulse, store completed.
REQ-014 SHALL have port err  output  1  one-cycle pulse, request rejected.
REQ-015 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-016 SHALL implement states IDLE, WRITE, DONE, ERR.
REQ-017 SHALL assert req_ready only in IDLE; a request is accepted on a cycle with req_valid && req_ready.
REQ-018 SHALL, on acceptance, register req_addr, req_data, and byte count N (1/2/4 for size 00/01/10), and set byte index to 0.
REQ-019 SHALL reject (IDLE->ERR) when size=11, size=01 with addr[0]=1, or size=10 with addr[1:0]!=0; no mem_we is issued for rejected requests.
REQ-020 SHALL go IDLE->WRITE on an accepted legal request.
REQ-021 SHALL, in WRITE, drive mem_we=1, mem_addr=base+idx (modulo 2^ADDR_W), mem_wdata=data[8*idx+7:8*idx] (little-endian; only the low N bytes of req_data are ever written).
REQ-022 SHALL hold mem_addr and mem_wdata stable while mem_we=1 and mem_ready=0.
REQ-023 SHALL increment idx on each mem_we && mem_ready; when that handshake occurs with idx=N-1, go WRITE->DONE.
REQ-024 SHALL, in DONE, assert done=1 for exactly one cycle, then go to IDLE.
REQ-025 SHALL, in ERR, assert err=1 for exactly one cycle, then go to IDLE.
REQ-026 SHALL ignore req_valid and req_* changes while busy; latched values alone determine the writes.
REQ-027 SHALL give latency, with mem_ready held 1: acceptance at cycle 0, writes cycles 1..N, done at cycle N+1, req_ready at N+2.
REQ-028 SHALL drive mem_we=0, mem_wdata=0, and mem_addr=0 in every state except WRITE.

Reset
REQ-029 SHALL, on rst_n=0, immediately enter IDLE and clear the registered address, data, idx, and N.
REQ-030 SHALL hold outputs during reset at req_ready=0, busy=0, mem_we=0, mem_addr=0, mem_wdata=0, done=0, err=0; req_ready SHALL go to 1 on the first clock edge after rst_n deasserts.
REQ-031 SHALL abort any in-progress store on reset mid-operation, with no further mem_we and no done/err pulse.

Verification
REQ-032 SHALL be covered by a directed test: SW addr=0x100, data=0xA1B2C3D4, mem_ready=1 -> writes (0x100,D4),(0x101,C3),(0x102,B2),(0x103,A1) on cycles 1-4, done on cycle 5.
REQ-033 SHALL be covered by a directed test: SH addr=0x202, data=0xFFFF8765 -> writes (0x202,65),(0x203,87) only, then done.
REQ-034 SHALL be covered by a directed test: SB addr=0x7, data=0x123456F0 -> single write (0x7,F0), done on cycle 2.
REQ-035 SHALL be covered by a directed test: SH addr=0x3, SW addr=0x2, and size=11 -> err pulse each time, zero mem_we cycles, req_ready back to 1 two cycles after acceptance.
REQ-036 SHALL be covered by a directed test: SW with mem_ready low for 3 cycles on byte 1 -> mem_addr/mem_wdata held at (base+1, data[15:8]) throughout, exactly 4 handshakes total.
REQ-037 SHALL be covered by a directed test: rst_n pulsed low after 2nd byte of SW -> mem_we drops immediately, no done pulse, req_ready=1 after release.
